// File: rtl/chan_mux_rr.sv
// chan_mux_rr: NCH-channel registered mux, manual or round-robin select.
// Ports: CLOCK_50/resetn, in_* (NCH valid/ready channels), mode, sel, out_* (1-entry reg).
module chan_mux_rr #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_ch
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load;
  logic             ch_found;
  logic [SEL_W-1:0] ch_idx;
  logic             xfer;
  logic [WIDTH-1:0] ch_data;

  // Channel index arithmetic modulo NCH; NCH need not be a power of two.
  function automatic logic [SEL_W-1:0] wrap(input int v);
    return SEL_W'((v >= NCH) ? v - NCH : v);
  endfunction

  always_comb begin
    ch_found = 1'b0;
    ch_idx   = '0;
    load     = !out_valid_q || out_ready;
    if (mode) begin
      // First valid channel scanning from ptr upward, wrapping.
      for (int i = 0; i < NCH; i++) begin
        if (!ch_found && in_valid[wrap(int'(ptr_q) + i)]) begin
          ch_found = 1'b1;
          ch_idx   = wrap(int'(ptr_q) + i);
        end
      end
    end else if (int'(sel) < NCH) begin
      ch_found = 1'b1;
      ch_idx   = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      in_ready[k] = load && ch_found && (ch_idx == SEL_W'(k));
    end
  end

  // Only the chosen slice is read, so X elsewhere cannot reach the outputs.
  assign ch_data = in_data[int'(ch_idx)*WIDTH +: WIDTH];
  assign xfer    = ch_found && load && in_valid[ch_idx];

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = ch_data;
      out_ch_d    = ch_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        ptr_d = wrap(int'(ch_idx) + 1);
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule
